// File: rtl/lower_layer_2_1_ctrl.sv
// Sequencing controller for the 2:1 lower-layer merge datapath: load/compare/swap/emit
// with a run counter that flags the last element of each fixed-length output run.
module lower_layer_2_1_ctrl #(
    parameter int RUN_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in_valid,
    output logic o_in_ready,
    input  logic i_cmp1,
    input  logic i_cmp2,
    output logic o_load,
    output logic o_swap,
    output logic o_sel,
    output logic o_out_valid,
    input  logic i_out_ready,
    output logic o_out_last,
    input  logic i_run_clr,
    output logic o_busy
);
    localparam int CNT_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_LEN - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, EMIT = 2'd2} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_sel;
    logic             r_swapped;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hs;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // After one swap cmp2 is ignored, so equal D1/D2 cannot keep the FSM in CMP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_in_valid) w_next = CMP;
            CMP:     if (!(i_cmp2 && !r_swapped)) w_next = EMIT;
            EMIT:    if (i_out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == IDLE);
        o_load      = (r_state == IDLE) && i_in_valid;
        o_swap      = (r_state == CMP) && i_cmp2 && !r_swapped;
        o_out_valid = (r_state == EMIT);
        o_busy      = (r_state != IDLE);
        o_sel       = r_sel;
        o_out_last  = (r_state == EMIT) && (r_cnt == LAST);
    end

    assign w_hs = o_out_valid && i_out_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel     <= 1'b0;
            r_swapped <= 1'b0;
        end else begin
            if (o_load)      r_swapped <= 1'b0;
            else if (o_swap) r_swapped <= 1'b1;
            if (r_state == CMP && !o_swap) r_sel <= i_cmp1;
        end
    end

    // Clear has priority over an output handshake in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          r_cnt <= '0;
        else if (i_run_clr) r_cnt <= '0;
        else if (w_hs)      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: tb/tb_lower_layer_2_1_ctrl.sv
// Directed bench for lower_layer_2_1_ctrl with RUN_LEN=4.
module tb_lower_layer_2_1_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, cmp1 = 1'b0, cmp2 = 1'b0, out_ready = 1'b0, run_clr = 1'b0;
    logic in_ready, load, swap, sel, out_valid, out_last, busy;
    int   tests = 0, fails = 0;

    lower_layer_2_1_ctrl #(.RUN_LEN(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_cmp1(cmp1), .i_cmp2(cmp2), .o_load(load), .o_swap(swap), .o_sel(sel),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_last(out_last),
        .i_run_clr(run_clr), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // mode: 0 no swap, 1 one swap then cmp2=0, 2 cmp2 held high throughout
    task automatic run_txn(input string nm, input bit c1, input int mode, input int stall,
                           input bit exp_last, input bit clr);
        in_valid = 1'b1; cmp2 = (mode == 2); cmp1 = c1;
        #1;
        tests++;
        if ({in_ready, load, swap, out_valid} !== 4'b1100) begin
            fails++; $display("FAIL %s accept: got rdy/load/swap/ov=%b want 1100", nm, {in_ready, load, swap, out_valid});
        end
        tick;
        in_valid = 1'b0;
        if (mode != 0) begin
            cmp2 = 1'b1;
            #1;
            tests++;
            if ({swap, load, out_valid, busy} !== 4'b1001) begin
                fails++; $display("FAIL %s swap cycle: got swap/load/ov/busy=%b want 1001", nm, {swap, load, out_valid, busy});
            end
            tick;
            cmp2 = (mode == 2);
        end
        cmp1 = c1;
        #1;
        tests++;
        if ({swap, out_valid, in_ready} !== 3'b000) begin
            fails++; $display("FAIL %s cmp cycle: got swap/ov/rdy=%b want 000", nm, {swap, out_valid, in_ready});
        end
        tick;
        cmp1 = ~c1; cmp2 = 1'b1;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            #1;
            tests++;
            if ({out_valid, sel, in_ready, load, swap, out_last} !== {1'b1, c1, 3'b000, exp_last}) begin
                fails++; $display("FAIL %s stall%0d: got ov/sel/rdy/load/swap/last=%b want %b", nm, i,
                    {out_valid, sel, in_ready, load, swap, out_last}, {1'b1, c1, 3'b000, exp_last});
            end
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1; run_clr = clr;
        #1;
        tests++;
        if ({out_valid, sel, out_last, busy} !== {1'b1, c1, exp_last, 1'b1}) begin
            fails++; $display("FAIL %s emit: got ov/sel/last/busy=%b want %b", nm,
                {out_valid, sel, out_last, busy}, {1'b1, c1, exp_last, 1'b1});
        end
        tick;
        out_ready = 1'b0; run_clr = 1'b0; cmp2 = 1'b0;
        #1;
        tests++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            fails++; $display("FAIL %s return idle: got ov/busy/rdy=%b want 001", nm, {out_valid, busy, in_ready});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            tests++;
            if ({in_ready, load, swap, sel, out_valid, out_last, busy} !== 7'b1000000) begin
                fails++; $display("FAIL reset_idle c%0d: got %b want 1000000", i,
                    {in_ready, load, swap, sel, out_valid, out_last, busy});
            end
        end
    endtask

    task automatic test_no_swap;
        run_txn("no_swap", 1'b1, 0, 0, 1'b0, 1'b0);   // element 0
    endtask

    task automatic test_swap;
        run_txn("swap", 1'b0, 1, 0, 1'b0, 1'b0);      // element 1
        run_txn("swap_hold", 1'b0, 2, 0, 1'b0, 1'b0); // element 2
    endtask

    task automatic test_backpressure;
        run_txn("bp", 1'b1, 0, 5, 1'b1, 1'b0);        // element 3 -> last
    endtask

    task automatic test_run_framing;
        bit exp [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        run_clr = 1'b1; tick; run_clr = 1'b0;
        for (int i = 0; i < 9; i++)
            run_txn($sformatf("frame%0d", i + 1), i[0], (i % 3 == 2) ? 1 : 0, 0, exp[i], 1'b0);
        // counter now at 1; clear on this handshake so the next output is element 0
        run_txn("clr_hs", 1'b1, 0, 0, 1'b0, 1'b1);
        run_txn("after_clr0", 1'b0, 0, 0, 1'b0, 1'b0);
        run_txn("after_clr1", 1'b1, 0, 0, 1'b0, 1'b0);
        run_txn("after_clr2", 1'b0, 0, 0, 1'b0, 1'b0);
        run_txn("after_clr3", 1'b1, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid;
        run_txn("pre_rst0", 1'b1, 0, 0, 1'b0, 1'b0);
        run_txn("pre_rst1", 1'b0, 0, 0, 1'b0, 1'b0);
        in_valid = 1'b1; cmp1 = 1'b1; cmp2 = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL mid_emit: got ov=%b want 1", out_valid);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({out_valid, busy, in_ready, sel, out_last} !== 5'b00100) begin
            fails++; $display("FAIL mid_rst: got ov/busy/rdy/sel/last=%b want 00100", {out_valid, busy, in_ready, sel, out_last});
        end
        tick;
        rst = 1'b0;
        tick;
        run_txn("post_rst0", 1'b0, 0, 0, 1'b0, 1'b0);
        run_txn("post_rst1", 1'b1, 1, 0, 1'b0, 1'b0);
        run_txn("post_rst2", 1'b0, 0, 0, 1'b0, 1'b0);
        run_txn("post_rst3", 1'b1, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset;
        test_no_swap;
        test_swap;
        test_backpressure;
        test_run_framing;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
